fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end: drives the word address into the combinational instruction memory (`InsMem`), captures the returned 32-bit word and its address, and hands them to decode through a valid/ready handshake. A 2-entry buffer decouples fetch from decode back-pressure. The block supports branch/jump redirects and stops on a halt word. It sits between the program counter logic and the IF/ID boundary of the core.

## Interface
- `ADDR_W`, 16, width of the instruction word address (`pc`).
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 16'h0000, first address fetched after reset.
- `DEPTH`, 2, output buffer entries (power of two, ≥2).
- `HALT_WORD`, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  ADDR_W  word address to `InsMem`; registered.
- `instruction`  in  DATA_W  word returned by `InsMem`, combinational from `pc`, same cycle.
- `redirect_valid`  in  1  load a new fetch address this cycle.
- `redirect_pc`  in  ADDR_W  target address for the redirect.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  DATA_W  head instruction.
- `out_pc`  out  ADDR_W  address of the head instruction.
- `halted`  out  1  fetch stopped on `HALT_WORD`.

## Operation
- States: `RUN` and `HALT`. Reset enters `RUN` with `pc = RESET_PC`.
- Pop: when `out_valid & out_ready`, the head is removed at the edge.
- Push (`RUN` only): when `count < DEPTH` or a pop occurs in the same cycle, the pair {`instruction`, `pc`} is written at the tail and `pc <= pc + 1`.
  - Addresses are word-granular, so the increment is +1.
  - The increment wraps modulo 2^ADDR_W (16'hFFFF → 16'h0000).
- No push: when the buffer is full with no pop, `pc` holds and nothing is written. The same word is re-read next cycle.
- Halt: if the pushed word equals `HALT_WORD`:
  - It is pushed normally, so decode still receives it.
  - State becomes `HALT` and `pc` stays at the halt word's address (no increment).
  - In `HALT`, no pushes occur. Pops continue until the buffer drains.
- Redirect has the highest priority and applies in any state:
  - Buffer is flushed (`count <= 0`) and `pc <= redirect_pc`; state becomes `RUN`.
  - No push and no pop occur that cycle, whatever the value of `out_ready`.
  - The word at the old `pc` is discarded.
- `out_instr` and `out_pc` are don't-care when `out_valid = 0`. The implementation drives them to 0 when the buffer is empty.

## Timing
- Reset values: `pc = RESET_PC`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `halted = 0`, `count = 0`, state `RUN`.
- Fetch latency: the first edge after `rst_n` rises captures `instruction` at `RESET_PC`, and `out_valid` is 1 after that edge.
- Throughput: one instruction per cycle while `out_ready = 1`.
- Redirect: `out_valid = 0` for exactly the cycle after the redirect edge. The first edge after that captures the word at `redirect_pc`.
- `halted` goes to 1 on the edge that pushes `HALT_WORD`, and to 0 on a redirect edge.
- `rst_n` asserted mid-operation immediately returns all outputs to their reset values and drops buffered entries.
- Handshake: `out_valid`, `out_instr` and `out_pc` stay stable while `out_valid & ~out_ready`, except when a redirect flushes the buffer.

## Structure
- Package `fetch_pkg`: state enum (`RUN`, `HALT`), `HALT_WORD`, and the `ADDR_W`/`DATA_W` defaults.
- Sub-module `fetch_buffer`: DEPTH-entry FIFO of {pc, instr}.
  - Ports: push, pop, flush; outputs full, empty, head.
  - Pointer wrap modulo DEPTH.
  - Flush has priority over push and pop.
- `fetch_unit`: `pc` register, state machine, and the push/redirect gating.

## Test plan
- Reset, then memory words 0–4 = 32'h1000_0000+i with `out_ready = 1` → `out_pc` 0,1,2,3,4 on consecutive cycles with the matching `out_instr`, and `out_valid` continuously 1 from the first edge.
- `out_ready = 0` for 5 cycles → buffer fills with pc 0 and 1, `pc` holds at 2, and head is stable at pc 0. Releasing `out_ready` → order 0,1,2 with no loss or duplicate.
- Redirect to 16'h0040 while full, with `out_ready = 1` → nothing popped that cycle, `out_valid = 0` the next cycle, then `out_pc = 16'h0040`.
- `HALT_WORD` at address 3 → pc 0–3 delivered, `halted = 1`, `pc` stays at 3, and `out_valid` drops after the drain. Redirect to 0 → fetch resumes and `halted = 0`.
- Redirect to 16'hFFFE → `out_pc` sequence FFFE, FFFF, 0000, 0001.
- `rst_n` pulsed low mid-stream with 2 entries buffered → outputs zero immediately and `pc = RESET_PC`. Fetch restarts from 0 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int unsigned FETCH_ADDR_W = 16;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam logic [FETCH_DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
module fetch_buffer import fetch_pkg::*; #(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ent_pc_q    [DEPTH];
  logic [DATA_W-1:0] ent_instr_q [DEPTH];
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_push  = push & ~flush & (~full | pop);
    do_pop   = pop & ~flush & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_pc_q[wr_ptr_q]    <= push_pc;
      ent_instr_q[wr_ptr_q] <= push_instr;
    end
  end

  assign head_pc    = empty ? '0 : ent_pc_q[rd_ptr_q];
  assign head_instr = empty ? '0 : ent_instr_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pc register, RUN/HALT control, redirect and
// push gating in front of a small decoupling buffer.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned        DATA_W    = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [DATA_W-1:0]  HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              buf_full, buf_empty;
  logic              push, pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    // A redirect suppresses both ends of the buffer for its cycle.
    pop  = out_valid & out_ready & ~redirect_valid;
    push = (state_q == RUN) & ~redirect_valid & (~buf_full | pop);
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (push) begin
      if (instruction == HALT_WORD) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (pc_q),
    .push_instr (instruction),
    .full       (buf_full),
    .empty      (buf_empty),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign pc        = pc_q;
  assign out_valid = ~buf_empty;
  assign halted    = (state_q == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural InsMem.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  logic [31:0] mem [0:65535];
  assign instruction = mem[pc];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  typedef struct {
    logic        rstn;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] eopc;
    logic [15:0] epc;
    logic        ehalt;
  } vec_t;

  vec_t tv[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic rstn, logic rdy, logic redir, logic [15:0] rpc,
                              logic ev, logic [15:0] eopc, logic [15:0] epc, logic ehalt);
    vec_t r;
    r.rstn = rstn; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.ev = ev; r.eopc = eopc; r.epc = epc; r.ehalt = ehalt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs just after.
  task automatic step(input string tag, input logic rstn, input logic rdy, input logic redir,
                      input logic [15:0] rpc, input logic ev, input logic [15:0] eopc,
                      input logic [31:0] einstr, input logic [15:0] epc, input logic ehalt);
    @(negedge clk);
    rst_n = rstn; out_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    #1;
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, ".out_pc"},    {16'd0, out_pc},    {16'd0, eopc});
    check({tag, ".out_instr"}, out_instr,          einstr);
    check({tag, ".pc"},        {16'd0, pc},        {16'd0, epc});
    check({tag, ".halted"},    {31'd0, halted},    {31'd0, ehalt});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 + i;

    // Streaming from reset.
    tv.push_back(mk(0,1,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,1,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0000,16'h0001,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0001,16'h0002,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0002,16'h0003,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0003,16'h0004,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0004,16'h0005,0));
    // Back-pressure from reset: fill, hold, release.
    tv.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,0,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0000,16'h0001,0));
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0000,16'h0002,0));
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0000,16'h0002,0));
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0000,16'h0002,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0000,16'h0002,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0001,16'h0003,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0002,16'h0004,0));
    // Redirect while full with out_ready high.
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0003,16'h0005,0));
    tv.push_back(mk(1,1,1,16'h0040, 1,16'h0003,16'h0005,0));
    tv.push_back(mk(1,1,0,16'h0000, 0,16'h0000,16'h0040,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0040,16'h0041,0));
    // Redirect near the top of the address space: pc wraps.
    tv.push_back(mk(1,1,1,16'hFFFE, 1,16'h0041,16'h0042,0));
    tv.push_back(mk(1,1,0,16'h0000, 0,16'h0000,16'hFFFE,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'hFFFE,16'hFFFF,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'hFFFF,16'h0000,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0000,16'h0001,0));
    // Two entries buffered, then asynchronous reset mid-stream.
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0001,16'h0002,0));
    tv.push_back(mk(1,0,0,16'h0000, 1,16'h0001,16'h0003,0));
    tv.push_back(mk(0,0,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,1,0,16'h0000, 0,16'h0000,16'h0000,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0000,16'h0001,0));
    tv.push_back(mk(1,1,0,16'h0000, 1,16'h0001,16'h0002,0));

    for (int i = 0; i < tv.size(); i++) begin
      step($sformatf("vec%0d", i), tv[i].rstn, tv[i].rdy, tv[i].redir, tv[i].rpc,
           tv[i].ev, tv[i].eopc, tv[i].ev ? 32'h1000_0000 + {16'd0, tv[i].eopc} : 32'd0,
           tv[i].epc, tv[i].ehalt);
    end

    // Halt word at address 3: deliver 0..3, stop, drain, then resume on redirect.
    mem[3] = 32'hFFFF_FFFF;
    step("h0", 0,1,0,16'h0000, 0,16'h0000,32'h0000_0000,16'h0000,0);
    step("h1", 1,1,0,16'h0000, 0,16'h0000,32'h0000_0000,16'h0000,0);
    step("h2", 1,1,0,16'h0000, 1,16'h0000,32'h1000_0000,16'h0001,0);
    step("h3", 1,1,0,16'h0000, 1,16'h0001,32'h1000_0001,16'h0002,0);
    step("h4", 1,1,0,16'h0000, 1,16'h0002,32'h1000_0002,16'h0003,0);
    step("h5", 1,1,0,16'h0000, 1,16'h0003,32'hFFFF_FFFF,16'h0003,1);
    step("h6", 1,1,0,16'h0000, 0,16'h0000,32'h0000_0000,16'h0003,1);
    step("h7", 1,1,1,16'h0000, 0,16'h0000,32'h0000_0000,16'h0003,1);
    step("h8", 1,1,0,16'h0000, 0,16'h0000,32'h0000_0000,16'h0000,0);
    step("h9", 1,1,0,16'h0000, 1,16'h0000,32'h1000_0000,16'h0001,0);
    mem[3] = 32'h1000_0003;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
